// File: rtl/alu_result_queue.sv
// alu_result_queue: FIFO between the ALU execution units and writeback.
// Each entry is {result, status, flag_we}. The head entry is presented
// first-word-fall-through with valid/ready. The architectural flags register
// is updated when an entry retires (pops), not when it is queued.
// Optional build macro: ALU_STICKY_OVF_EN makes the overflow flag sticky
// across flag-writing retirements. Only flags_clr or rst clears it.
module alu_result_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [3:0]       in_status,
   input  logic             in_flag_we,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_status,
   output logic [3:0]       flags,
   input  logic             flags_clr,
   output logic [CW-1:0]    count
);

   // Shared ALU status bit positions
   localparam int ST_CARRY    = 0;
   localparam int ST_NEG      = 1;
   localparam int ST_ZERO     = 2;
   localparam int ST_OVERFLOW = 3;

   localparam int AW = $clog2(DEPTH);
   localparam int EW = WIDTH + 5;

   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [3:0]       r_flags;

   logic             w_push;
   logic             w_pop;
   logic [EW-1:0]    w_head;
   logic [3:0]       w_head_status;
   logic             w_head_we;
   logic [3:0]       w_flags_next;
   logic [CW-1:0]    w_count_next;

   // Handshake qualifiers; reset forces both sides idle
   assign in_ready  = !rst && (r_count != CW'(DEPTH));
   assign out_valid = !rst && (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Head entry is read straight from storage so it is visible the cycle after the push
   assign w_head        = r_mem[r_rd_ptr];
   assign out_result    = w_head[EW-1:5];
   assign w_head_status = w_head[4:1];
   assign w_head_we     = w_head[0];
   assign out_status    = w_head_status;

   assign flags = r_flags;
   assign count = r_count;

   // Next flags value: clear first, then a flag-writing retirement overrides it
   always_comb begin
      w_flags_next = r_flags;
      if (flags_clr) begin
         w_flags_next = 4'b0000;
      end
      if (w_pop && w_head_we) begin
         w_flags_next = w_head_status;
`ifdef ALU_STICKY_OVF_EN
         w_flags_next[ST_OVERFLOW] = r_flags[ST_OVERFLOW] | w_head_status[ST_OVERFLOW];
`endif
      end
   end

   // Occupancy: unchanged when a push and a pop coincide
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   // Storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_result, in_status, in_flag_we};
      end
   end

   // Pointers, occupancy and flags; reset discards every entry and blocks retirement
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_flags  <= 4'b0000;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
         r_flags <= w_flags_next;
      end
   end

   // Unused-bit sink for positions only referenced under the optional macro
   logic w_unused;
   assign w_unused = ^{ST_CARRY[0], ST_NEG[0], ST_ZERO[0], ST_OVERFLOW[0]};

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: table-driven directed bench for alu_result_queue,
// plus hand-written sequences for sticky overflow and reset mid-operation.
module tb_alu_result_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_result = '0;
   logic [3:0]       in_status = '0;
   logic             in_flag_we = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_status;
   logic [3:0]       flags;
   logic             flags_clr = 1'b0;
   logic [CW-1:0]    count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_status(in_status), .in_flag_we(in_flag_we),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_status(out_status),
      .flags(flags), .flags_clr(flags_clr), .count(count)
   );

   // Upstream must hold valid and data while stalled
   logic             r_stall = 1'b0;
   logic [WIDTH-1:0] r_stall_res = '0;
   logic [3:0]       r_stall_st = '0;
   always @(posedge clk) begin
      if (r_stall && !rst) begin
         assert (in_valid && in_result == r_stall_res && in_status == r_stall_st)
            else $error("handshake hold violated");
      end
      r_stall     <= in_valid && !in_ready && !rst;
      r_stall_res <= in_result;
      r_stall_st  <= in_status;
   end

   typedef struct {
      logic        iv;
      logic [31:0] res;
      logic [3:0]  st;
      logic        fw;
      logic        ordy;
      logic        clr;
      logic        e_irdy;
      logic        e_ovld;
      logic [31:0] e_res;
      logic [3:0]  e_st;
      int          e_cnt;
      logic [3:0]  e_flg;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic iv, input logic [31:0] res, input logic [3:0] st,
                    input logic fw, input logic ordy, input logic clr,
                    input logic e_irdy, input logic e_ovld, input logic [31:0] e_res,
                    input logic [3:0] e_st, input int e_cnt, input logic [3:0] e_flg);
      vec_t t;
      t.iv = iv; t.res = res; t.st = st; t.fw = fw; t.ordy = ordy; t.clr = clr;
      t.e_irdy = e_irdy; t.e_ovld = e_ovld; t.e_res = e_res; t.e_st = e_st;
      t.e_cnt = e_cnt; t.e_flg = e_flg;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] res, input logic [3:0] st,
                        input logic fw, input logic ordy, input logic clr);
      in_valid = iv; in_result = res; in_status = st; in_flag_we = fw;
      out_ready = ordy; flags_clr = clr;
   endtask

   initial begin
      // Columns: iv res st fw ordy clr | in_ready out_valid head_res head_st count flags
      v(0, 32'h0,  4'h0, 0, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0); // idle after reset
      v(1, 32'h1,  4'h1, 0, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0); // fill
      v(1, 32'h2,  4'h2, 0, 0, 0,  1, 1, 32'h1,  4'h1, 1, 4'h0);
      v(1, 32'h3,  4'h3, 0, 0, 0,  1, 1, 32'h1,  4'h1, 2, 4'h0);
      v(1, 32'h4,  4'h4, 0, 0, 0,  1, 1, 32'h1,  4'h1, 3, 4'h0);
      v(1, 32'h5,  4'h5, 0, 0, 0,  0, 1, 32'h1,  4'h1, 4, 4'h0); // full, 5th refused
      v(1, 32'h5,  4'h5, 0, 1, 0,  0, 1, 32'h1,  4'h1, 4, 4'h0); // full + pop: no push-through
      v(1, 32'h5,  4'h5, 0, 1, 0,  1, 1, 32'h2,  4'h2, 3, 4'h0);
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h3,  4'h3, 3, 4'h0);
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h4,  4'h4, 2, 4'h0);
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h5,  4'h5, 1, 4'h0);
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0); // empty ignores out_ready
      v(1, 32'h10, 4'h0, 0, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0); // build count=2
      v(1, 32'h11, 4'h0, 0, 0, 0,  1, 1, 32'h10, 4'h0, 1, 4'h0);
      v(1, 32'h12, 4'h0, 0, 1, 0,  1, 1, 32'h10, 4'h0, 2, 4'h0); // 6 push+pop cycles
      v(1, 32'h13, 4'h0, 0, 1, 0,  1, 1, 32'h11, 4'h0, 2, 4'h0);
      v(1, 32'h14, 4'h0, 0, 1, 0,  1, 1, 32'h12, 4'h0, 2, 4'h0);
      v(1, 32'h15, 4'h0, 0, 1, 0,  1, 1, 32'h13, 4'h0, 2, 4'h0);
      v(1, 32'h16, 4'h0, 0, 1, 0,  1, 1, 32'h14, 4'h0, 2, 4'h0);
      v(1, 32'h17, 4'h0, 0, 1, 0,  1, 1, 32'h15, 4'h0, 2, 4'h0);
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h16, 4'h0, 2, 4'h0);
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h17, 4'h0, 1, 4'h0);
      v(0, 32'h0,  4'h0, 0, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0);
      v(1, 32'h20, 4'h4, 1, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0); // ZERO, flag_we=1
      v(1, 32'h21, 4'h2, 0, 0, 0,  1, 1, 32'h20, 4'h4, 1, 4'h0); // NEG, flag_we=0
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h20, 4'h4, 2, 4'h0); // flags still 0 before retire
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h21, 4'h2, 1, 4'h4); // ZERO after first pop
      v(0, 32'h0,  4'h0, 0, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h4); // still ZERO
      v(1, 32'h30, 4'h1, 1, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h4); // CARRY
      v(1, 32'h31, 4'h2, 1, 0, 0,  1, 1, 32'h30, 4'h1, 1, 4'h4); // NEG
      v(0, 32'h0,  4'h0, 0, 1, 0,  1, 1, 32'h30, 4'h1, 2, 4'h4);
      v(0, 32'h0,  4'h0, 0, 1, 1,  1, 1, 32'h31, 4'h2, 1, 4'h1); // clr collides with pop
      v(0, 32'h0,  4'h0, 0, 0, 1,  1, 0, 32'h0,  4'h0, 0, 4'h2); // pop won -> NEG; clr alone
      v(0, 32'h0,  4'h0, 0, 0, 0,  1, 0, 32'h0,  4'h0, 0, 4'h0);

      // Reset held: both sides idle
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         drive(vecs[i].iv, vecs[i].res, vecs[i].st, vecs[i].fw, vecs[i].ordy, vecs[i].clr);
         @(negedge clk);
         chk($sformatf("row%0d_in_ready", i), in_ready, vecs[i].e_irdy);
         chk($sformatf("row%0d_out_valid", i), out_valid, vecs[i].e_ovld);
         chk($sformatf("row%0d_count", i), count, vecs[i].e_cnt);
         chk($sformatf("row%0d_flags", i), flags, vecs[i].e_flg);
         if (vecs[i].e_ovld) begin
            chk($sformatf("row%0d_out_result", i), out_result, vecs[i].e_res);
            chk($sformatf("row%0d_out_status", i), out_status, vecs[i].e_st);
         end
         $display("row %0d: iv=%0d res=0x%0h ordy=%0d clr=%0d -> cnt=%0d ovld=%0d head=0x%0h flags=%b",
                  i, vecs[i].iv, vecs[i].res, vecs[i].ordy, vecs[i].clr, count, out_valid, out_result, flags);
      end

      // Sticky overflow: retire OVERFLOW then ZERO, both flag-writing
      @(posedge clk); #1; drive(1, 32'h40, 4'h8, 1, 0, 0);
      @(posedge clk); #1; drive(1, 32'h41, 4'h4, 1, 0, 0);
      @(posedge clk); #1; drive(0, 32'h0, 4'h0, 0, 1, 0);
      @(negedge clk); chk("ovf_head1", out_result, 32'h40);
      @(posedge clk); #1;
      @(negedge clk); chk("ovf_flags_after1", flags, 4'h8);
      chk("ovf_head2", out_result, 32'h41);
      @(posedge clk); #1; drive(0, 32'h0, 4'h0, 0, 0, 0);
      @(negedge clk);
`ifdef ALU_STICKY_OVF_EN
      chk("ovf_flags_after2", flags, 4'hC);
`else
      chk("ovf_flags_after2", flags, 4'h4);
`endif
      chk("ovf_count", count, 0);
      $display("sticky seq: flags=%b", flags);

      // Reset with 3 entries queued and a flag-writing pop pending on the reset edge
      @(posedge clk); #1; drive(1, 32'h50, 4'h1, 1, 0, 0);
      @(posedge clk); #1; drive(1, 32'h51, 4'h2, 1, 0, 0);
      @(posedge clk); #1; drive(1, 32'h52, 4'h3, 1, 0, 0);
      @(posedge clk); #1; drive(0, 32'h0, 4'h0, 0, 1, 0);
      @(negedge clk); chk("pre_rst_count", count, 3);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_count", count, 0);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_flags", flags, 4'h0);
      chk("post_rst_in_ready", in_ready, 1);
      $display("reset seq: count=%0d ovld=%0d flags=%b", count, out_valid, flags);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
